i2c_game_target: RTL and testbench
==================================

Name: i2c_game_target

Overview:
- I2C target (responder) for the game-event link. It is the far end of the master-side game I2C controller and runs on the display/score board.
- It oversamples SCL/SDA on the system clock, matches its 7-bit address, and ACKs the address and each data byte.
- It collects a fixed 2-byte write frame (opcode, payload) and commits it on STOP as single-cycle event pulses plus held status registers.
- Reads and malformed frames are rejected without disturbing committed state.

Parameters:
- TARGET_ADDR, 7'h12, 7-bit I2C address this block answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).
- CLK_HZ, 100_000_000, system clock rate; sets the 50-cycle spike-filter floor (standard-mode SCL only).

Ports:
- iClk  in  1  system clock, 100 MHz.
- iRst_n  in  1  asynchronous active-low reset.
- SCL  in  1  I2C clock from the master.
- SDA  inout  1  I2C data, open-drain: driven 1'b0 or high-Z only.
- oShow  out  1  pulse: SHOW frame committed.
- oGame_Win  out  2  held: payload[1:0] of the last SHOW frame.
- oGame_Final  out  1  pulse: FINAL frame committed.
- oGame_Result  out  2  held: payload[1:0] of the last FINAL frame.
- oUp_P1, oDown_P1, oUp_P2, oDown_P2  out  1 each  pulses: score step per player.
- oRestart  out  1  pulse: RESTART frame committed.
- oFrame_Err  out  1  pulse: addressed frame discarded.
- oBusy  out  1  high from START until STOP.

Behaviour:
- Reset: asynchronous active-low on iRst_n. All outputs are 0, SDA is high-Z, FSM=IDLE, and the synchronisers are preset to 1.
- Input path: SYNC_STAGES-deep synchronisers on SCL and SDA. Edges are detected from the last two synced samples.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- Bus timing: data bits are sampled on SCL rise; SDA drive changes only on the cycle after SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits MSB first. On the 8th rise, compare {addr, rw}.
    - Match with rw=0 -> ADDR_ACK.
    - Otherwise -> IGNORE. rw=1 gets a NACK (SDA left released).
  - ADDR_ACK: drive SDA low from the SCL fall after bit 8 to the SCL fall after the 9th clock, then go to DATA.
  - DATA: shift 8 bits. The byte counter (2-bit, saturating at 3) increments. Byte 1 is stored as opcode, byte 2 as payload.
    - Bytes 1-2 -> DATA_ACK.
    - A 3rd byte -> not ACKed, frame flagged bad, then IGNORE.
  - DATA_ACK: same drive window as ADDR_ACK, then back to DATA.
  - IGNORE: SDA released, waiting for STOP/START.
- START or STOP in any state aborts the current byte. A repeated START re-enters ADDR and clears the byte counter and flags; no commit happens.
- Commit happens on STOP only, one cycle after STOP is detected:
  - Requires an address match with rw=0, exactly 2 bytes, and a known opcode.
  - Opcode decode:
    - 0x01 -> oShow, and oGame_Win <= payload[1:0].
    - 0x02 -> oGame_Final, and oGame_Result <= payload[1:0].
    - 0x03 -> oUp_P1 = payload[0], oDown_P1 = payload[1].
    - 0x04 -> same as 0x03 for P2.
    - 0x05 -> oRestart.
  - For 0x03/0x04 with payload[1:0]=2'b11, no pulse is produced and oFrame_Err fires.
- Error: an address-matched frame with byte count not equal to 2, an unknown opcode, or the 2'b11 case above raises oFrame_Err for 1 cycle at STOP. Held outputs are unchanged.
- Pulses are exactly 1 iClk wide. At most one event pulse fires per frame.
- oBusy is 1 from the START detect cycle to the STOP detect cycle inclusive.
- Reset asserted mid-frame: SDA is released immediately and all state clears. The bus is re-armed only by the next START.

Decomposition:
- Package i2c_game_pkg holds:
  - opcode localparams (OP_SHOW=8'h01, OP_FINAL=8'h02, OP_SCORE_P1=8'h03, OP_SCORE_P2=8'h04, OP_RESTART=8'h05);
  - the FSM state enum;
  - the frame length constant FRAME_BYTES=2.
- Sub-module i2c_bus_sync contains the synchronisers plus START/STOP/SCL-rise/SCL-fall edge detection.
- The FSM and commit decoder stay in i2c_game_target.

Test Plan:
- Write 0x24 (addr 0x12, W), 0x01, 0x02, STOP -> three ACKs; oShow pulses 1 cycle after STOP; oGame_Win=2'b10 and held.
- Write to 0x12: 0x03, 0x01, STOP -> oUp_P1 single pulse, others 0. Repeat with opcode 0x04 and payload 0x02 -> oDown_P2 single pulse.
- Address 0x26 (0x13, W), or 0x25 (0x12, R) -> SDA never driven low; no pulses; oBusy high until STOP.
- Write 0x12: 0x02, 0x03, 0x00, STOP -> 3rd byte NACKed; oFrame_Err pulses; oGame_Result unchanged at its previous value.
- Write 0x12: 0x05, then repeated START, then 0x12: 0x05, 0x00, STOP -> exactly one oRestart pulse after the final STOP.
- Assert iRst_n=0 during ADDR_ACK low drive -> SDA high-Z in the same cycle; all outputs 0; next full frame is accepted normally.

Source files
------------

// File: rtl/i2c_game_pkg.sv
// Shared opcodes, frame length and FSM state encoding for the game-event I2C target.
package i2c_game_pkg;

   localparam logic [7:0] OP_SHOW     = 8'h01;
   localparam logic [7:0] OP_FINAL    = 8'h02;
   localparam logic [7:0] OP_SCORE_P1 = 8'h03;
   localparam logic [7:0] OP_SCORE_P2 = 8'h04;
   localparam logic [7:0] OP_RESTART  = 8'h05;

   localparam logic [1:0] FRAME_BYTES = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StData,
      StDataAck,
      StIgnore
   } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with START/STOP and SCL edge detection on the synced samples.
module i2c_bus_sync #(
   parameter int unsigned SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_sync_o,
   output logic start_o,
   output logic stop_o,
   output logic scl_rise_o,
   output logic scl_fall_o
);

   logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
   logic                  scl_prev_q, sda_prev_q;
   logic                  scl_s, sda_s;

   // Preset to 1 so an idle bus produces no edges when reset releases.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_s      = scl_sync_q[SyncStages-1];
   assign sda_s      = sda_sync_q[SyncStages-1];
   assign sda_sync_o = sda_s;

   assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign scl_rise_o = scl_s & ~scl_prev_q;
   assign scl_fall_o = ~scl_s & scl_prev_q;

endmodule

// File: rtl/i2c_game_target.sv
// I2C target for the game-event link: collects a 2-byte write frame (opcode, payload)
// and commits it on STOP as one-cycle event pulses plus held status registers.
module i2c_game_target
   import i2c_game_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = 7'h12,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CLK_HZ      = 100_000_000
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       SCL,
   inout  wire        SDA,
   output logic       oShow,
   output logic [1:0] oGame_Win,
   output logic       oGame_Final,
   output logic [1:0] oGame_Result,
   output logic       oUp_P1,
   output logic       oDown_P1,
   output logic       oUp_P2,
   output logic       oDown_P2,
   output logic       oRestart,
   output logic       oFrame_Err,
   output logic       oBusy
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   // Standard-mode SCL high time (4 us) must span the 50-cycle spike floor.
   if (CLK_HZ < 12_500_000) begin : g_bad_clk
      $error("CLK_HZ too low for standard-mode SCL");
   end

   logic sda_s, start_det, stop_det, scl_rise, scl_fall;

   i2c_bus_sync #(
      .SyncStages(SYNC_STAGES)
   ) u_bus_sync (
      .clk_i     (iClk),
      .rst_ni    (iRst_n),
      .scl_i     (SCL),
      .sda_i     (SDA),
      .sda_sync_o(sda_s),
      .start_o   (start_det),
      .stop_o    (stop_det),
      .scl_rise_o(scl_rise),
      .scl_fall_o(scl_fall)
   );

   i2c_state_e state_q, state_d;
   logic [7:0] shift_q, shift_d, opcode_q, opcode_d, payload_q, payload_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [1:0] byte_cnt_q, byte_cnt_d;
   logic       addr_ok_q, addr_ok_d, bad_q, bad_d;
   logic       ack_drv_q, ack_drv_d, sda_low_q, sda_low_d, busy_q, busy_d;
   logic [1:0] win_q, win_d, result_q, result_d;
   logic       show_q, show_d, final_q, final_d, up1_q, up1_d, down1_q, down1_d;
   logic       up2_q, up2_d, down2_q, down2_d, restart_q, restart_d, err_q, err_d;
   logic [7:0] shifted;

   assign shifted = {shift_q[6:0], sda_s};

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      opcode_d   = opcode_q;
      payload_d  = payload_q;
      addr_ok_d  = addr_ok_q;
      bad_d      = bad_q;
      ack_drv_d  = ack_drv_q;
      sda_low_d  = sda_low_q;
      busy_d     = busy_q;
      if (start_det) begin
         state_d    = StAddr;
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 2'd0;
         addr_ok_d  = 1'b0;
         bad_d      = 1'b0;
         ack_drv_d  = 1'b0;
         sda_low_d  = 1'b0;
         busy_d     = 1'b1;
      end else if (stop_det) begin
         // addr_ok is consumed here so a stray second STOP cannot recommit.
         state_d   = StIdle;
         addr_ok_d = 1'b0;
         ack_drv_d = 1'b0;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StIgnore: ;
            StAddr: begin
               if (scl_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (shifted == {TARGET_ADDR, 1'b0}) begin
                        addr_ok_d = 1'b1;
                        state_d   = StAddrAck;
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StData: begin
               if (scl_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
                     if (byte_cnt_q == 2'd0) begin
                        opcode_d = shifted;
                        state_d  = StDataAck;
                     end else if (byte_cnt_q == 2'd1) begin
                        payload_d = shifted;
                        state_d   = StDataAck;
                     end else begin
                        bad_d   = 1'b1;
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StAddrAck, StDataAck: begin
               // First SCL fall opens the ACK window, the next one closes it.
               if (scl_fall) begin
                  if (!ack_drv_q) begin
                     ack_drv_d = 1'b1;
                     sda_low_d = 1'b1;
                  end else begin
                     ack_drv_d = 1'b0;
                     sda_low_d = 1'b0;
                     bit_cnt_d = 3'd0;
                     state_d   = StData;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      show_d    = 1'b0;
      final_d   = 1'b0;
      up1_d     = 1'b0;
      down1_d   = 1'b0;
      up2_d     = 1'b0;
      down2_d   = 1'b0;
      restart_d = 1'b0;
      err_d     = 1'b0;
      win_d     = win_q;
      result_d  = result_q;
      if (stop_det && !start_det && addr_ok_q) begin
         if (bad_q || byte_cnt_q != FRAME_BYTES) begin
            err_d = 1'b1;
         end else begin
            case (opcode_q)
               OP_SHOW: begin
                  show_d = 1'b1;
                  win_d  = payload_q[1:0];
               end
               OP_FINAL: begin
                  final_d  = 1'b1;
                  result_d = payload_q[1:0];
               end
               OP_SCORE_P1: begin
                  if (payload_q[1:0] == 2'b11) begin
                     err_d = 1'b1;
                  end else begin
                     up1_d   = payload_q[0];
                     down1_d = payload_q[1];
                  end
               end
               OP_SCORE_P2: begin
                  if (payload_q[1:0] == 2'b11) begin
                     err_d = 1'b1;
                  end else begin
                     up2_d   = payload_q[0];
                     down2_d = payload_q[1];
                  end
               end
               OP_RESTART: restart_d = 1'b1;
               default:    err_d     = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q    <= StIdle;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 2'd0;
         opcode_q   <= 8'h00;
         payload_q  <= 8'h00;
         addr_ok_q  <= 1'b0;
         bad_q      <= 1'b0;
         ack_drv_q  <= 1'b0;
         sda_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         win_q      <= 2'b00;
         result_q   <= 2'b00;
         show_q     <= 1'b0;
         final_q    <= 1'b0;
         up1_q      <= 1'b0;
         down1_q    <= 1'b0;
         up2_q      <= 1'b0;
         down2_q    <= 1'b0;
         restart_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         opcode_q   <= opcode_d;
         payload_q  <= payload_d;
         addr_ok_q  <= addr_ok_d;
         bad_q      <= bad_d;
         ack_drv_q  <= ack_drv_d;
         sda_low_q  <= sda_low_d;
         busy_q     <= busy_d;
         win_q      <= win_d;
         result_q   <= result_d;
         show_q     <= show_d;
         final_q    <= final_d;
         up1_q      <= up1_d;
         down1_q    <= down1_d;
         up2_q      <= up2_d;
         down2_q    <= down2_d;
         restart_q  <= restart_d;
         err_q      <= err_d;
      end
   end

   assign SDA          = sda_low_q ? 1'b0 : 1'bz;
   assign oShow        = show_q;
   assign oGame_Win    = win_q;
   assign oGame_Final  = final_q;
   assign oGame_Result = result_q;
   assign oUp_P1       = up1_q;
   assign oDown_P1     = down1_q;
   assign oUp_P2       = up2_q;
   assign oDown_P2     = down2_q;
   assign oRestart     = restart_q;
   assign oFrame_Err   = err_q;
   assign oBusy        = busy_q | start_det;

endmodule

// File: tb/tb_i2c_game_target.sv
// Directed bench for i2c_game_target: bit-banged I2C master with per-scenario tasks.
module tb_i2c_game_target;

   localparam int Q = 10;
   localparam logic [7:0] P_SHOW  = 8'h80;
   localparam logic [7:0] P_FINAL = 8'h40;
   localparam logic [7:0] P_UP1   = 8'h20;
   localparam logic [7:0] P_DN1   = 8'h10;
   localparam logic [7:0] P_UP2   = 8'h08;
   localparam logic [7:0] P_DN2   = 8'h04;
   localparam logic [7:0] P_RST   = 8'h02;
   localparam logic [7:0] P_ERR   = 8'h01;

   logic iClk = 1'b0;
   logic iRst_n = 1'b0;
   logic scl = 1'b1;
   logic m_sda_low = 1'b0;
   wire  sda_bus;

   logic       oShow, oGame_Final, oUp_P1, oDown_P1, oUp_P2, oDown_P2;
   logic       oRestart, oFrame_Err, oBusy;
   logic [1:0] oGame_Win, oGame_Result;
   logic [7:0] pv;

   int checks = 0;
   int errors = 0;
   int pulse_cycles = 0;
   int dut_low = 0;
   int frame_base = 0;

   pullup (sda_bus);
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

   i2c_game_target dut (
      .iClk        (iClk),
      .iRst_n      (iRst_n),
      .SCL         (scl),
      .SDA         (sda_bus),
      .oShow       (oShow),
      .oGame_Win   (oGame_Win),
      .oGame_Final (oGame_Final),
      .oGame_Result(oGame_Result),
      .oUp_P1      (oUp_P1),
      .oDown_P1    (oDown_P1),
      .oUp_P2      (oUp_P2),
      .oDown_P2    (oDown_P2),
      .oRestart    (oRestart),
      .oFrame_Err  (oFrame_Err),
      .oBusy       (oBusy)
   );

   assign pv = {oShow, oGame_Final, oUp_P1, oDown_P1, oUp_P2, oDown_P2, oRestart, oFrame_Err};

   always #5 iClk = ~iClk;

   always @(posedge iClk) begin
      if (pv != 8'h00) pulse_cycles++;
      if (!m_sda_low && sda_bus === 1'b0) dut_low++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge iClk);
   endtask

   task automatic i2c_start();
      frame_base = pulse_cycles;
      m_sda_low = 1'b1;
      tick(2 * Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_rstart();
      m_sda_low = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_sda_low = 1'b1;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (pv !== 8'h00 || oGame_Win !== 2'b00 || oGame_Result !== 2'b00 || oBusy !== 1'b0) begin
         errors++;
         $display("FAIL %s outputs got pv=%b win=%b res=%b busy=%b want all 0",
                  name, pv, oGame_Win, oGame_Result, oBusy);
      end
      checks++;
      if (sda_bus !== 1'b1) begin
         errors++;
         $display("FAIL %s sda got %b want released 1", name, sda_bus);
      end
   endtask

   // Returns ack=0 when the target pulled SDA low on the 9th clock.
   task automatic write_byte(input logic [7:0] b, input bit rst_mid, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = ~b[i];
         tick(Q);
         scl = 1'b1;
         tick(2 * Q);
         scl = 1'b0;
         tick(Q);
      end
      m_sda_low = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      ack = sda_bus;
      if (rst_mid) begin
         iRst_n = 1'b0;
         #1;
         check_all_zero("reset in ack");
         tick(2);
         iRst_n = 1'b1;
      end
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic xfer(input string name, input bit rep, input int n, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                       input logic [3:0] exp_ack);
      logic [7:0] bs [4];
      logic       ack;
      bs[0] = b0;
      bs[1] = b1;
      bs[2] = b2;
      bs[3] = b3;
      if (rep) i2c_rstart();
      else i2c_start();
      for (int i = 0; i < n; i++) begin
         write_byte(bs[i], 1'b0, ack);
         checks++;
         if (ack !== exp_ack[i]) begin
            errors++;
            $display("FAIL %s ack byte %0d got %b want %b", name, i, ack, exp_ack[i]);
         end
      end
   endtask

   // STOP, then per-cycle checks: pulse exactly on the 3rd sample, busy through the 2nd.
   task automatic stop_watch(input string name, input logic [7:0] exp_p, input logic exp_busy);
      logic [7:0] want;
      logic       want_busy;
      checks++;
      if (pulse_cycles !== frame_base) begin
         errors++;
         $display("FAIL %s mid-frame pulses got %0d want 0", name, pulse_cycles - frame_base);
      end
      m_sda_low = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_sda_low = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         want = (k == 3) ? exp_p : 8'h00;
         checks++;
         if (pv !== want) begin
            errors++;
            $display("FAIL %s pulses cycle %0d got %b want %b", name, k, pv, want);
         end
         if (k <= 3) begin
            want_busy = (k < 3) ? exp_busy : 1'b0;
            checks++;
            if (oBusy !== want_busy) begin
               errors++;
               $display("FAIL %s busy cycle %0d got %b want %b", name, k, oBusy, want_busy);
            end
         end
      end
      tick(2 * Q);
      checks++;
      if (pulse_cycles - frame_base !== ((exp_p != 8'h00) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s pulse cycles got %0d want %0d", name, pulse_cycles - frame_base,
                  (exp_p != 8'h00) ? 1 : 0);
      end
   endtask

   task automatic check_held(input string name, input logic [1:0] w, input logic [1:0] r);
      checks++;
      if (oGame_Win !== w || oGame_Result !== r) begin
         errors++;
         $display("FAIL %s held got win=%b res=%b want win=%b res=%b",
                  name, oGame_Win, oGame_Result, w, r);
      end
   endtask

   task automatic test_reset();
      tick(3);
      check_all_zero("reset");
      iRst_n = 1'b1;
      tick(5);
      check_all_zero("after reset");
   endtask

   task automatic test_show();
      xfer("show", 1'b0, 3, 8'h24, 8'h01, 8'h02, 8'h00, 4'b0000);
      checks++;
      if (oBusy !== 1'b1) begin
         errors++;
         $display("FAIL show busy mid-frame got %b want 1", oBusy);
      end
      stop_watch("show", P_SHOW, 1'b1);
      check_held("show", 2'b10, 2'b00);
      tick(50);
      check_held("show later", 2'b10, 2'b00);
   endtask

   task automatic test_score();
      xfer("up p1", 1'b0, 3, 8'h24, 8'h03, 8'h01, 8'h00, 4'b0000);
      stop_watch("up p1", P_UP1, 1'b1);
      xfer("down p2", 1'b0, 3, 8'h24, 8'h04, 8'h02, 8'h00, 4'b0000);
      stop_watch("down p2", P_DN2, 1'b1);
      xfer("down p1", 1'b0, 3, 8'h24, 8'h03, 8'h02, 8'h00, 4'b0000);
      stop_watch("down p1", P_DN1, 1'b1);
      check_held("score", 2'b10, 2'b00);
   endtask

   task automatic test_nack();
      int dl0;
      dl0 = dut_low;
      xfer("wrong addr", 1'b0, 3, 8'h26, 8'h01, 8'h02, 8'h00, 4'b0111);
      checks++;
      if (oBusy !== 1'b1) begin
         errors++;
         $display("FAIL wrong addr busy got %b want 1", oBusy);
      end
      stop_watch("wrong addr", 8'h00, 1'b1);
      xfer("read", 1'b0, 1, 8'h25, 8'h00, 8'h00, 8'h00, 4'b0001);
      stop_watch("read", 8'h00, 1'b1);
      checks++;
      if (dut_low !== dl0) begin
         errors++;
         $display("FAIL nack sda driven low cycles got %0d want 0", dut_low - dl0);
      end
      check_held("nack", 2'b10, 2'b00);
   endtask

   task automatic test_overflow();
      xfer("final", 1'b0, 3, 8'h24, 8'h02, 8'h01, 8'h00, 4'b0000);
      stop_watch("final", P_FINAL, 1'b1);
      check_held("final", 2'b10, 2'b01);
      xfer("3 bytes", 1'b0, 4, 8'h24, 8'h02, 8'h03, 8'h00, 4'b1000);
      stop_watch("3 bytes", P_ERR, 1'b1);
      check_held("3 bytes", 2'b10, 2'b01);
   endtask

   task automatic test_back_to_back();
      xfer("rs first", 1'b0, 2, 8'h24, 8'h05, 8'h00, 8'h00, 4'b0000);
      xfer("rs second", 1'b1, 3, 8'h24, 8'h05, 8'h00, 8'h00, 4'b0000);
      stop_watch("restart", P_RST, 1'b1);
   endtask

   task automatic test_errors();
      xfer("bad op", 1'b0, 3, 8'h24, 8'h07, 8'h00, 8'h00, 4'b0000);
      stop_watch("bad op", P_ERR, 1'b1);
      xfer("score 11", 1'b0, 3, 8'h24, 8'h04, 8'h03, 8'h00, 4'b0000);
      stop_watch("score 11", P_ERR, 1'b1);
      xfer("short", 1'b0, 2, 8'h24, 8'h01, 8'h00, 8'h00, 4'b0000);
      stop_watch("short", P_ERR, 1'b1);
      check_held("errors", 2'b10, 2'b01);
   endtask

   task automatic test_reset_mid();
      logic ack;
      i2c_start();
      write_byte(8'h24, 1'b1, ack);
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL reset mid ack before reset got %b want 0", ack);
      end
      stop_watch("post-reset stop", 8'h00, 1'b0);
      xfer("after reset", 1'b0, 3, 8'h24, 8'h01, 8'h01, 8'h00, 4'b0000);
      stop_watch("after reset", P_SHOW, 1'b1);
      check_held("after reset", 2'b01, 2'b00);
   endtask

   initial begin
      test_reset();
      test_show();
      test_score();
      test_nack();
      test_overflow();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
